cache_flush_ctrl: RTL and testbench

- Sequencer that walks every set and way of a set-associative cache, writing back dirty lines and then optionally invalidating the whole array.
- Sits beside the cache tag/valid/dirty arrays and the replacement logic.
- Drives the flush address and way into the cache address mux, and handshakes writebacks with the bus interface.
- Asserts a hold on replacement-state updates (LRU/LFSR) while it is active.

---
 rtl/cache_flush_ctrl.sv | 145 ++++++++++++++
 tb/tb_cache_flush_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_flush_ctrl.sv
// Flush sequencer: walks every set/way, writes back valid+dirty lines, then
// optionally pulses a whole-array invalidate before signalling completion.
module cache_flush_ctrl #(
   parameter int unsigned NUMWAYS  = 4,
   parameter int unsigned NUMLINES = 128,
   parameter int unsigned SETLEN   = $clog2(NUMLINES)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               FlushReq,
   input  logic               InvalidateReq,
   input  logic               LineValid,
   input  logic               LineDirty,
   input  logic               WritebackAck,
   output logic [SETLEN-1:0]  FlushAdr,
   output logic [NUMWAYS-1:0] FlushWay,
   output logic               FlushActive,
   output logic               WritebackReq,
   output logic               ClearDirty,
   output logic               InvalidateCache,
   output logic               ReplHold,
   output logic               FlushDone
);

   localparam int unsigned WAYLEN = $clog2(NUMWAYS);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StChk,
      StWb,
      StClr,
      StInv,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [SETLEN-1:0]   set_q, set_d;
   logic [WAYLEN-1:0]   way_q, way_d;
   logic                inv_pend_q, inv_pend_d;

   logic                last_line;
   state_e              adv_state;
   logic [SETLEN-1:0]   adv_set;
   logic [WAYLEN-1:0]   adv_way;

   assign last_line = (set_q == SETLEN'(NUMLINES - 1)) && (way_q == WAYLEN'(NUMWAYS - 1));

   // Next position after a line is finished; the counters park at the last
   // line and only return to 0 when heading into DONE.
   always_comb begin
      adv_state = StRd;
      adv_set   = set_q;
      adv_way   = way_q;
      if (last_line) begin
         if (inv_pend_q) begin
            adv_state = StInv;
         end else begin
            adv_state = StDone;
            adv_set   = '0;
            adv_way   = '0;
         end
      end else if (way_q == WAYLEN'(NUMWAYS - 1)) begin
         adv_way = '0;
         adv_set = set_q + SETLEN'(1);
      end else begin
         adv_way = way_q + WAYLEN'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      set_d      = set_q;
      way_d      = way_q;
      inv_pend_d = inv_pend_q;
      unique case (state_q)
         StIdle: begin
            if (FlushReq) begin
               state_d    = StRd;
               set_d      = '0;
               way_d      = '0;
               inv_pend_d = InvalidateReq;
            end else if (InvalidateReq) begin
               state_d    = StInv;
               inv_pend_d = 1'b0;
            end
         end
         StRd: state_d = StChk;
         StChk: begin
            if (LineValid && LineDirty) begin
               state_d = StWb;
            end else begin
               state_d = adv_state;
               set_d   = adv_set;
               way_d   = adv_way;
            end
         end
         StWb: begin
            if (WritebackAck) begin
               state_d = StClr;
            end
         end
         StClr: begin
            state_d = adv_state;
            set_d   = adv_set;
            way_d   = adv_way;
         end
         StInv: begin
            state_d = StDone;
            set_d   = '0;
            way_d   = '0;
         end
         StDone: begin
            state_d    = StIdle;
            inv_pend_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         set_q      <= '0;
         way_q      <= '0;
         inv_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         set_q      <= set_d;
         way_q      <= way_d;
         inv_pend_q <= inv_pend_d;
      end
   end

   // Outputs decode registered state only, so reset clears them at once.
   assign FlushAdr        = set_q;
   assign FlushWay        = NUMWAYS'(1) << way_q;
   assign FlushActive     = (state_q != StIdle);
   assign ReplHold        = FlushActive;
   assign WritebackReq    = (state_q == StWb);
   assign ClearDirty      = (state_q == StClr);
   assign InvalidateCache = (state_q == StInv);
   assign FlushDone       = (state_q == StDone);

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl on a 4-set x 4-way array with a
// registered tag-array model and a programmable writeback acknowledger.
module tb_cache_flush_ctrl;

   localparam int unsigned NW = 4;
   localparam int unsigned NL = 4;
   localparam int unsigned SL = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          FlushReq = 1'b0;
   logic          InvalidateReq = 1'b0;
   logic          LineValid;
   logic          LineDirty;
   logic          WritebackAck;
   logic [SL-1:0] FlushAdr;
   logic [NW-1:0] FlushWay;
   logic          FlushActive;
   logic          WritebackReq;
   logic          ClearDirty;
   logic          InvalidateCache;
   logic          ReplHold;
   logic          FlushDone;

   cache_flush_ctrl #(
      .NUMWAYS (NW),
      .NUMLINES(NL)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .FlushReq       (FlushReq),
      .InvalidateReq  (InvalidateReq),
      .LineValid      (LineValid),
      .LineDirty      (LineDirty),
      .WritebackAck   (WritebackAck),
      .FlushAdr       (FlushAdr),
      .FlushWay       (FlushWay),
      .FlushActive    (FlushActive),
      .WritebackReq   (WritebackReq),
      .ClearDirty     (ClearDirty),
      .InvalidateCache(InvalidateCache),
      .ReplHold       (ReplHold),
      .FlushDone      (FlushDone)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic mem_v [16];
   logic mem_d [16];
   int   ack_delay = 1;
   logic stray_ack = 1'b0;
   int   wb_cnt = 0;

   function automatic int way_idx(input logic [NW-1:0] w);
      int r = 0;
      for (int i = 0; i < NW; i++) if (w[i]) r = i;
      return r;
   endfunction

   // Tag array: read data appears one cycle after the address.
   always @(posedge clk) begin
      LineValid <= mem_v[int'(FlushAdr) * NW + way_idx(FlushWay)];
      LineDirty <= mem_d[int'(FlushAdr) * NW + way_idx(FlushWay)];
   end

   // Ack goes high in the ack_delay-th cycle of WritebackReq.
   always @(negedge clk) begin
      wb_cnt       <= WritebackReq ? wb_cnt + 1 : 0;
      WritebackAck <= stray_ack || (WritebackReq && (wb_cnt + 1 == ack_delay));
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) begin
         mem_v[i] = 1'b0;
         mem_d[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      FlushReq = 1'b0;
      InvalidateReq = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic flush;
      logic inv;
      int   dirty_idx;
      logic dirty_valid;
      int   delay;
      logic stray;
      logic sweep;
      int   exp_done;
      int   exp_wb;
      int   exp_clr;
      int   exp_inv;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int done_cyc, done_cnt, wb_cyc, clr_cnt, inv_cyc, inv_cnt;
      int sweep_bad, wbadr_bad, hold_bad, move_bad, wait_n;
      logic seen;
      logic [SL+NW+5:0] outs;
      logic [SL+NW+5:0] rst_outs;

      //         flush inv  didx  dval dly stray sweep done wb clr inv
      vecs[0] = '{1'b1, 1'b0, -1, 1'b0, 1, 1'b1, 1'b1, 33, 0, 0, 0};
      vecs[1] = '{1'b1, 1'b0,  9, 1'b1, 3, 1'b0, 1'b0, 37, 3, 1, 0};
      vecs[2] = '{1'b1, 1'b1, -1, 1'b0, 1, 1'b0, 1'b1, 34, 0, 0, 33};
      vecs[3] = '{1'b0, 1'b1, -1, 1'b0, 1, 1'b0, 1'b0,  2, 0, 0, 1};
      vecs[4] = '{1'b1, 1'b0,  7, 1'b0, 1, 1'b0, 1'b1, 33, 0, 0, 0};
      vecs[5] = '{1'b1, 1'b1, 15, 1'b1, 1, 1'b0, 1'b0, 36, 1, 1, 35};
      vecs[6] = '{1'b1, 1'b0,  0, 1'b1, 2, 1'b0, 1'b0, 36, 2, 1, 0};

      clear_mem();
      #1;
      rst_outs = {2'd0, 4'b0001, 6'b0};
      outs = {FlushAdr, FlushWay, FlushActive, WritebackReq, ClearDirty,
              InvalidateCache, ReplHold, FlushDone};
      check("reset_outputs", int'(outs), int'(rst_outs));
      @(negedge clk);
      reset = 1'b1;

      for (int v = 0; v < 7; v++) begin
         do_reset();
         clear_mem();
         if (vecs[v].dirty_idx >= 0) begin
            mem_d[vecs[v].dirty_idx] = 1'b1;
            mem_v[vecs[v].dirty_idx] = vecs[v].dirty_valid;
         end
         ack_delay = vecs[v].delay;
         stray_ack = vecs[v].stray;
         FlushReq = vecs[v].flush;
         InvalidateReq = vecs[v].inv;
         done_cyc = 0; done_cnt = 0; wb_cyc = 0; clr_cnt = 0; inv_cyc = 0; inv_cnt = 0;
         sweep_bad = 0; wbadr_bad = 0; hold_bad = 0; move_bad = 0;
         for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            FlushReq = 1'b0;
            InvalidateReq = 1'b0;
            if (FlushDone) begin
               done_cnt++;
               if (done_cyc == 0) done_cyc = c;
            end
            if (InvalidateCache) begin
               inv_cnt++;
               if (inv_cyc == 0) inv_cyc = c;
            end
            if (ClearDirty) clr_cnt++;
            if (WritebackReq) begin
               wb_cyc++;
               if (int'(FlushAdr) * NW + way_idx(FlushWay) != vecs[v].dirty_idx) wbadr_bad++;
            end
            if (ReplHold != FlushActive) hold_bad++;
            if (FlushAdr != 0 || FlushWay != 4'b0001) move_bad++;
            if (vecs[v].sweep && c <= 32) begin
               if (int'(FlushAdr) != ((c - 1) / 2) / NW ||
                   FlushWay != (4'b0001 << (((c - 1) / 2) % NW)) || !FlushActive)
                  sweep_bad++;
            end
         end
         check($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_done);
         check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
         check($sformatf("v%0d_wb_cycles", v), wb_cyc, vecs[v].exp_wb);
         check($sformatf("v%0d_clear_dirty", v), clr_cnt, vecs[v].exp_clr);
         check($sformatf("v%0d_inv_cycle", v), inv_cyc, vecs[v].exp_inv);
         check($sformatf("v%0d_inv_pulses", v), inv_cnt, (vecs[v].exp_inv != 0) ? 1 : 0);
         check($sformatf("v%0d_repl_hold", v), hold_bad, 0);
         if (vecs[v].exp_wb != 0) check($sformatf("v%0d_wb_addr", v), wbadr_bad, 0);
         if (vecs[v].sweep) check($sformatf("v%0d_sweep", v), sweep_bad, 0);
         if (!vecs[v].flush) check($sformatf("v%0d_no_sweep", v), move_bad, 0);
      end
      stray_ack = 1'b0;

      // Asynchronous reset mid-walk.
      do_reset();
      clear_mem();
      FlushReq = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         FlushReq = 1'b0;
      end
      check("walk_active_before_reset", int'(FlushActive), 1);
      #2 reset = 1'b0;
      #1;
      outs = {FlushAdr, FlushWay, FlushActive, WritebackReq, ClearDirty,
              InvalidateCache, ReplHold, FlushDone};
      check("async_reset_outputs", int'(outs), int'(rst_outs));
      @(negedge clk);
      reset = 1'b1;

      // Reset while a writeback is outstanding.
      mem_v[0] = 1'b1;
      mem_d[0] = 1'b1;
      ack_delay = 100;
      FlushReq = 1'b1;
      seen = 1'b0;
      wait_n = 0;
      while (!seen && wait_n < 10) begin
         @(negedge clk);
         FlushReq = 1'b0;
         wait_n++;
         seen = WritebackReq;
      end
      check("wb_reached", int'(seen), 1);
      #2 reset = 1'b0;
      #1;
      check("wb_reset_req", int'(WritebackReq), 0);
      check("wb_reset_clr", int'(ClearDirty), 0);
      @(negedge clk);
      reset = 1'b1;
      clear_mem();
      ack_delay = 1;
      FlushReq = 1'b1;
      @(negedge clk);
      FlushReq = 1'b0;
      check("restart_addr", int'({FlushActive, FlushAdr, FlushWay}), int'({1'b1, 2'd0, 4'b0001}));

      // Request held across DONE restarts after one IDLE cycle.
      do_reset();
      FlushReq = 1'b1;
      seen = 1'b0;
      wait_n = 0;
      while (!seen && wait_n < 60) begin
         @(negedge clk);
         wait_n++;
         seen = FlushDone;
      end
      check("held_req_done", int'(seen), 1);
      @(negedge clk);
      check("held_req_idle", int'(FlushActive), 0);
      @(negedge clk);
      check("held_req_restart", int'({FlushActive, FlushAdr, FlushWay}),
            int'({1'b1, 2'd0, 4'b0001}));
      FlushReq = 1'b0;
      do_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
